// File: rtl/gal_tri_arb_pkg.sv
// Shared types, width helpers and default parameters for the
// tristate bus arbiter (gal_tri_bus_arbiter and gal_tri_rr_pick).
package gal_tri_arb_pkg;

   localparam int DEF_N        = 4;
   localparam int DEF_MAX_HOLD = 8;
   localparam int DEF_TURN_CYC = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } arb_state_t;

   // index width for n requesters, never below 1 bit
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // width of a counter that must hold values 0..lim, never below 1 bit
   function automatic int cnt_w(input int lim);
      return (lim < 1) ? 1 : $clog2(lim + 1);
   endfunction

endpackage

// File: rtl/gal_tri_rr_pick.sv
// Combinational round-robin pick: lowest index >= ptr with req set, wrapping.
// Ports: req (requests), ptr (start index), win (winner index), any (req != 0).
module gal_tri_rr_pick
   import gal_tri_arb_pkg::*;
#(
   parameter int N  = DEF_N,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] win,
   output logic          any
);

   int j;

   always_comb begin
      win = '0;
      any = 1'b0;
      j   = 0;
      for (int i = 0; i < N; i++) begin
         j = (int'(ptr) + i) % N;
         if (!any && req[j[IW-1:0]]) begin
            any = 1'b1;
            win = j[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/gal_tri_bus_arbiter.sv
// Round-robin arbiter producing registered one-hot output enables for N
// tristate drivers on one net, with TURN_CYC all-low cycles between owners.
// Ports: C clock, R sync active-high reset, REQ requests, GNT grants,
// OE tristate enables, OWNER current/last owner, BUSY in GRANT or TURN.
// Build option: GAL_TRI_ARB_PARK_EN keeps the last owner driving in IDLE.
module gal_tri_bus_arbiter
   import gal_tri_arb_pkg::*;
#(
   parameter int N        = DEF_N,
   parameter int MAX_HOLD = DEF_MAX_HOLD,
   parameter int TURN_CYC = DEF_TURN_CYC
) (
   input  logic                  C,
   input  logic                  R,
   input  logic [N-1:0]          REQ,
   output logic [N-1:0]          GNT,
   output logic [N-1:0]          OE,
   output logic [idx_w(N)-1:0]   OWNER,
   output logic                  BUSY
);

   localparam int IW = idx_w(N);
   localparam int HW = cnt_w(MAX_HOLD);
   localparam int TW = cnt_w(TURN_CYC);
   localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);
   localparam logic [TW-1:0] TMAX = TW'(TURN_CYC);
   // unlimited hold still saturates, just at all-ones
   localparam logic [HW-1:0] HSAT = (MAX_HOLD == 0) ? '1 : HMAX;

   arb_state_t    state_q, state_n;
   logic [N-1:0]  gnt_q, gnt_n;
   logic [N-1:0]  oe_q, oe_n;
   logic [IW-1:0] owner_q, owner_n;
   logic [IW-1:0] ptr_q, ptr_n;
   logic [HW-1:0] hold_q, hold_n;
   logic [TW-1:0] turn_q, turn_n;

   logic [IW-1:0] win;
   logic          any;
   logic          park_hop;

   gal_tri_rr_pick #(.N(N), .IW(IW)) u_pick (
      .req (REQ),
      .ptr (ptr_q),
      .win (win),
      .any (any)
   );

   function automatic logic [N-1:0] onehot(input logic [IW-1:0] w);
      onehot    = '0;
      onehot[w] = 1'b1;
   endfunction

   // In IDLE a nonzero OE means the bus is parked; a different winner
   // must first sit through a turnaround.
`ifdef GAL_TRI_ARB_PARK_EN
   assign park_hop = (|oe_q) && (win != owner_q);
`else
   assign park_hop = 1'b0;
`endif

   always_ff @(posedge C) begin
      if (R) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         oe_q    <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
         hold_q  <= '0;
         turn_q  <= '0;
      end else begin
         state_q <= state_n;
         gnt_q   <= gnt_n;
         oe_q    <= oe_n;
         owner_q <= owner_n;
         ptr_q   <= ptr_n;
         hold_q  <= hold_n;
         turn_q  <= turn_n;
      end
   end

   always_comb begin
      state_n = state_q;
      gnt_n   = gnt_q;
      oe_n    = oe_q;
      owner_n = owner_q;
      ptr_n   = ptr_q;
      hold_n  = hold_q;
      turn_n  = turn_q;
      unique case (state_q)
         IDLE: begin
            if (any && park_hop) begin
               state_n = TURN;
               gnt_n   = '0;
               oe_n    = '0;
               turn_n  = TW'(1);
            end else if (any) begin
               state_n = GRANT;
               gnt_n   = onehot(win);
               oe_n    = onehot(win);
               owner_n = win;
               hold_n  = HW'(1);
            end
         end
         GRANT: begin
            if (REQ[owner_q] && (MAX_HOLD == 0 || hold_q < HMAX)) begin
               if (hold_q != HSAT)
                  hold_n = hold_q + 1'b1;
            end else begin
               state_n = TURN;
               gnt_n   = '0;
               oe_n    = '0;
               ptr_n   = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;
               turn_n  = TW'(1);
            end
         end
         TURN: begin
            if (turn_q >= TMAX) begin
               if (any) begin
                  state_n = GRANT;
                  gnt_n   = onehot(win);
                  oe_n    = onehot(win);
                  owner_n = win;
                  hold_n  = HW'(1);
               end else begin
                  state_n = IDLE;
`ifdef GAL_TRI_ARB_PARK_EN
                  oe_n    = onehot(owner_q);
`else
                  oe_n    = '0;
`endif
               end
            end else begin
               turn_n = turn_q + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign GNT   = gnt_q;
   assign OE    = oe_q;
   assign OWNER = owner_q;
   assign BUSY  = (state_q != IDLE);

endmodule

// File: tb/tb_gal_tri_bus_arbiter.sv
// Self-checking bench for gal_tri_bus_arbiter: two instances
// (MAX_HOLD 8 and 2) share clock, reset and requests.
module tb_gal_tri_bus_arbiter;

   localparam int TC = 1;
`ifdef GAL_TRI_ARB_PARK_EN
   localparam bit PARK = 1'b1;
`else
   localparam bit PARK = 1'b0;
`endif

   typedef struct packed {
      logic [3:0] gnt;
      logic [3:0] oe;
      logic [1:0] owner;
      logic       busy;
   } exp_t;

   logic       C = 1'b0;
   logic       R = 1'b1;
   logic [3:0] REQ = 4'b0000;
   logic [3:0] GNT, OE, GNT2, OE2;
   logic [1:0] OWNER, OWNER2;
   logic       BUSY, BUSY2;

   int checks   = 0;
   int failures = 0;
   bit started  = 1'b0;

   exp_t sb[$];

   always #5 C = ~C;

   gal_tri_bus_arbiter #(.N(4), .MAX_HOLD(8), .TURN_CYC(TC)) dut (
      .C(C), .R(R), .REQ(REQ), .GNT(GNT), .OE(OE),
      .OWNER(OWNER), .BUSY(BUSY)
   );

   gal_tri_bus_arbiter #(.N(4), .MAX_HOLD(2), .TURN_CYC(TC)) dut2 (
      .C(C), .R(R), .REQ(REQ), .GNT(GNT2), .OE(OE2),
      .OWNER(OWNER2), .BUSY(BUSY2)
   );

   function automatic exp_t mk(input logic [3:0] g, input logic [3:0] o,
                               input logic [1:0] w, input logic b);
      exp_t e;
      e.gnt = g; e.oe = o; e.owner = w; e.busy = b;
      return e;
   endfunction

   task automatic tick;
      @(posedge C);
      #1;
   endtask

   task automatic do_reset;
      R = 1'b1; REQ = 4'b0000;
      tick();
      R = 1'b0;
   endtask

   // invariant monitors: one-hot0 OE and turnaround gap between owners
   logic [3:0] last1 = '0, last2 = '0;
   int gap1 = TC, gap2 = TC;
   always @(negedge C) begin
      if (started) begin
         checks++;
         if (!$onehot0(OE) || !$onehot0(OE2)) begin
            failures++;
            $display("FAIL onehot0 got oe=%b oe2=%b required one-hot0", OE, OE2);
         end
         checks++;
         if (OE != 0 && last1 != 0 && OE != last1 && gap1 < TC) begin
            failures++;
            $display("FAIL gap got %0d zero cycles %b->%b required >=%0d",
                     gap1, last1, OE, TC);
         end
         if (OE == 0) gap1++; else begin last1 = OE; gap1 = 0; end
         checks++;
         if (OE2 != 0 && last2 != 0 && OE2 != last2 && gap2 < TC) begin
            failures++;
            $display("FAIL gap2 got %0d zero cycles %b->%b required >=%0d",
                     gap2, last2, OE2, TC);
         end
         if (OE2 == 0) gap2++; else begin last2 = OE2; gap2 = 0; end
      end
   end

   task automatic test_reset;
      exp_t e;
      R = 1'b1; REQ = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) R = 1'b0;
         sb.push_back(i < 2 ? mk(4'b0000, 4'b0000, 2'd0, 1'b0)
                            : mk(4'b0001, 4'b0001, 2'd0, 1'b1));
         tick();
         started = 1'b1;
         e = sb.pop_front();
         checks++;
         if ({GNT, OE, OWNER, BUSY} !== e) begin
            failures++;
            $display("FAIL reset step%0d got gnt=%b oe=%b owner=%0d busy=%b required gnt=%b oe=%b owner=%0d busy=%b",
                     i, GNT, OE, OWNER, BUSY, e.gnt, e.oe, e.owner, e.busy);
         end
      end
   endtask

   task automatic test_hold;
      logic [3:0] rq[$];
      exp_t ex[$];
      exp_t e;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         rq.push_back(4'b0100); ex.push_back(mk(4'b0100, 4'b0100, 2'd2, 1'b1));
      end
      rq.push_back(4'b0100); ex.push_back(mk(4'b0000, 4'b0000, 2'd2, 1'b1));
      rq.push_back(4'b0100); ex.push_back(mk(4'b0100, 4'b0100, 2'd2, 1'b1));
      rq.push_back(4'b0000); ex.push_back(mk(4'b0000, 4'b0000, 2'd2, 1'b1));
      rq.push_back(4'b0000);
      ex.push_back(mk(4'b0000, PARK ? 4'b0100 : 4'b0000, 2'd2, 1'b0));
      foreach (rq[i]) begin
         REQ = rq[i];
         sb.push_back(ex[i]);
         tick();
         e = sb.pop_front();
         checks++;
         if ({GNT, OE, OWNER, BUSY} !== e) begin
            failures++;
            $display("FAIL hold step%0d got gnt=%b oe=%b owner=%0d busy=%b required gnt=%b oe=%b owner=%0d busy=%b",
                     i, GNT, OE, OWNER, BUSY, e.gnt, e.oe, e.owner, e.busy);
         end
      end
   endtask

   task automatic test_back_to_back;
      exp_t e;
      logic [3:0] oh;
      R = 1'b1; REQ = 4'b1111;
      tick();
      R = 1'b0;
      for (int k = 0; k < 13; k++) begin
         oh = 4'b0001 << ((k / 3) % 4);
         sb.push_back((k % 3 == 2) ? mk(4'b0000, 4'b0000, 2'((k / 3) % 4), 1'b1)
                                   : mk(oh, oh, 2'((k / 3) % 4), 1'b1));
         tick();
         e = sb.pop_front();
         checks++;
         if ({GNT2, OE2, OWNER2, BUSY2} !== e) begin
            failures++;
            $display("FAIL rotate step%0d got gnt=%b oe=%b owner=%0d busy=%b required gnt=%b oe=%b owner=%0d busy=%b",
                     k, GNT2, OE2, OWNER2, BUSY2, e.gnt, e.oe, e.owner, e.busy);
         end
      end
   endtask

   task automatic test_drop;
      logic [3:0] rq[$];
      exp_t ex[$];
      exp_t e;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         rq.push_back(4'b1010); ex.push_back(mk(4'b0010, 4'b0010, 2'd1, 1'b1));
      end
      rq.push_back(4'b1000); ex.push_back(mk(4'b0000, 4'b0000, 2'd1, 1'b1));
      rq.push_back(4'b1000); ex.push_back(mk(4'b1000, 4'b1000, 2'd3, 1'b1));
      foreach (rq[i]) begin
         REQ = rq[i];
         sb.push_back(ex[i]);
         tick();
         e = sb.pop_front();
         checks++;
         if ({GNT, OE, OWNER, BUSY} !== e) begin
            failures++;
            $display("FAIL drop step%0d got gnt=%b oe=%b owner=%0d busy=%b required gnt=%b oe=%b owner=%0d busy=%b",
                     i, GNT, OE, OWNER, BUSY, e.gnt, e.oe, e.owner, e.busy);
         end
      end
   endtask

   task automatic test_reset_mid_grant;
      logic [3:0] rq[$];
      logic       rr[$];
      exp_t ex[$];
      exp_t e;
      do_reset();
      rq.push_back(4'b0100); rr.push_back(1'b0);
      ex.push_back(mk(4'b0100, 4'b0100, 2'd2, 1'b1));
      rq.push_back(4'b0100); rr.push_back(1'b0);
      ex.push_back(mk(4'b0100, 4'b0100, 2'd2, 1'b1));
      rq.push_back(4'b0100); rr.push_back(1'b1);
      ex.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0));
      rq.push_back(4'b0110); rr.push_back(1'b0);
      ex.push_back(mk(4'b0010, 4'b0010, 2'd1, 1'b1));
      foreach (rq[i]) begin
         REQ = rq[i];
         R = rr[i];
         sb.push_back(ex[i]);
         tick();
         e = sb.pop_front();
         checks++;
         if ({GNT, OE, OWNER, BUSY} !== e) begin
            failures++;
            $display("FAIL rst_mid step%0d got gnt=%b oe=%b owner=%0d busy=%b required gnt=%b oe=%b owner=%0d busy=%b",
                     i, GNT, OE, OWNER, BUSY, e.gnt, e.oe, e.owner, e.busy);
         end
      end
      R = 1'b0;
   endtask

   task automatic test_park;
      logic [3:0] rq[$];
      exp_t ex[$];
      exp_t e;
      do_reset();
      rq.push_back(4'b0000); ex.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0));
      rq.push_back(4'b0100); ex.push_back(mk(4'b0100, 4'b0100, 2'd2, 1'b1));
      rq.push_back(4'b0000); ex.push_back(mk(4'b0000, 4'b0000, 2'd2, 1'b1));
      rq.push_back(4'b0000);
      ex.push_back(mk(4'b0000, PARK ? 4'b0100 : 4'b0000, 2'd2, 1'b0));
      rq.push_back(4'b0000);
      ex.push_back(mk(4'b0000, PARK ? 4'b0100 : 4'b0000, 2'd2, 1'b0));
      rq.push_back(4'b0001);
      ex.push_back(PARK ? mk(4'b0000, 4'b0000, 2'd2, 1'b1)
                        : mk(4'b0001, 4'b0001, 2'd0, 1'b1));
      rq.push_back(4'b0001); ex.push_back(mk(4'b0001, 4'b0001, 2'd0, 1'b1));
      rq.push_back(4'b0000); ex.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b1));
      rq.push_back(4'b0000);
      ex.push_back(mk(4'b0000, PARK ? 4'b0001 : 4'b0000, 2'd0, 1'b0));
      rq.push_back(4'b0001); ex.push_back(mk(4'b0001, 4'b0001, 2'd0, 1'b1));
      foreach (rq[i]) begin
         REQ = rq[i];
         sb.push_back(ex[i]);
         tick();
         e = sb.pop_front();
         checks++;
         if ({GNT, OE, OWNER, BUSY} !== e) begin
            failures++;
            $display("FAIL park step%0d got gnt=%b oe=%b owner=%0d busy=%b required gnt=%b oe=%b owner=%0d busy=%b",
                     i, GNT, OE, OWNER, BUSY, e.gnt, e.oe, e.owner, e.busy);
         end
      end
   endtask

   initial begin
      test_reset();
      test_hold();
      test_back_to_back();
      test_drop();
      test_reset_mid_grant();
      test_park();
      REQ = 4'b0000;
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
